mdu_iter: RTL

Iterative multiply/divide unit for the MIPS integer pipeline, executing MULT, MULTU, DIV and DIVU.
- Processes one bit per cycle using a shift-and-add / restoring-subtract datapath built around the team's adder cell.
- Writes the HI/LO result pair consumed by MFHI/MFLO.
- The pipeline launches it with a start pulse, stalls on busy, and collects the result when done is asserted.

---
 rtl/mdu_iter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-subtract step per cycle.
// Handshake: start is accepted only while busy=0; done is a one-cycle pulse qualifying hi/lo.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] ph_q, ph_d;
  logic [WIDTH-1:0] pl_q, pl_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  // Signed ops run on magnitudes; signs are reapplied in FIX.
  assign a_neg = ~op[0] & src_a[WIDTH-1];
  assign b_neg = ~op[0] & src_b[WIDTH-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  // Multiply: {ph,pl} shifts right, pl starts as multiplier. Divide: ph is the
  // partial remainder, pl shifts the dividend out and the quotient in.
  assign mul_sum   = {1'b0, ph_q} + (pl_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
  assign div_shift = {ph_q, pl_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, m_q};
  assign div_diff  = div_shift[WIDTH-1:0] - m_q;

  assign prod     = {ph_q, pl_q};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quot_fix = neg_res_q ? -pl_q : pl_q;
  assign rem_fix  = neg_rem_q ? -ph_q : ph_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    ph_d      = ph_q;
    pl_d      = pl_q;
    m_d       = m_q;
    a_raw_d   = a_raw_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CALC;
          cnt_d     = CNT_W'(WIDTH);
          is_div_d  = op[1];
          a_raw_d   = src_a;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dbz_d     = 1'b0;
          ph_d      = '0;
          pl_d      = op[1] ? a_mag : b_mag;
          m_d       = op[1] ? b_mag : a_mag;
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (is_div_q) begin
            ph_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
            pl_d = {pl_q[WIDTH-2:0], div_ge};
          end else begin
            ph_d = mul_sum[WIDTH:1];
            pl_d = {mul_sum[0], pl_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            if (m_q == '0) begin
              lo_d  = '1;
              hi_d  = a_raw_q;
              dbz_d = 1'b1;
            end else begin
              lo_d = quot_fix;
              hi_d = rem_fix;
            end
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      ph_q      <= '0;
      pl_q      <= '0;
      m_q       <= '0;
      a_raw_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      ph_q      <= ph_d;
      pl_q      <= pl_d;
      m_q       <= m_d;
      a_raw_q   <= a_raw_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule
